// File: rtl/reporte_ciclos.sv
// Sends a three-byte UART report (header, count low, count high) of the cycle
// count captured on the rising edge of the processor halt signal.
module reporte_ciclos #(
  parameter int unsigned        CONTADOR_LENGTH = 11,
  parameter int unsigned        NB_DATA         = 8,
  parameter logic [NB_DATA-1:0] HEADER          = 8'hA5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [CONTADOR_LENGTH-1:0] i_cuenta,
  input  logic                       i_halt,
  input  logic                       i_tx_done,
  output logic                       o_tx_start,
  output logic [NB_DATA-1:0]         o_tx_data,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned IDX_W    = 2;
  localparam logic [IDX_W-1:0] IDX_LAST = 2'd2;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [CONTADOR_LENGTH-1:0] cap_q, cap_d;
  logic [NB_DATA-1:0]         data_q, data_d;
  logic                       halt_q;
  logic                       start_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       halt_rise;

  // Byte of the frame addressed by the index; the high byte is zero-extended.
  function automatic logic [NB_DATA-1:0] sel_byte(input logic [IDX_W-1:0]           idx,
                                                  input logic [CONTADOR_LENGTH-1:0] cap);
    logic [NB_DATA-1:0] b;
    b = '0;
    case (idx)
      2'd0:    b = HEADER;
      2'd1:    b = NB_DATA'(cap[7:0]);
      2'd2:    b = NB_DATA'(cap[CONTADOR_LENGTH-1:8]);
      default: b = '0;
    endcase
    return b;
  endfunction

  assign halt_rise = i_halt & ~halt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (halt_rise) begin
          cap_d   = i_cuenta;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (i_tx_done) begin
          if (idx_q != IDX_LAST) begin
            idx_d   = IDX_W'(idx_q + 2'd1);
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!i_halt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Load the outgoing byte as SEND is entered so it is valid with tx_start.
    if (state_d == SEND) data_d = sel_byte(idx_d, cap_d);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cap_q   <= '0;
      data_q  <= '0;
      halt_q  <= 1'b1;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      halt_q  <= i_halt;
      start_q <= (state_d == SEND);
      busy_q  <= (state_d == SEND) || (state_d == WAIT);
      done_q  <= (state_d == DONE);
    end
  end

  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_reporte_ciclos.sv
// Randomized bench for reporte_ciclos: a UART responder pops expected bytes
// from a queue filled with the frame computed from each captured count.
module tb_reporte_ciclos;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] cuenta;
  logic        halt;
  logic        tick_main;
  logic        tick_resp = 1'b0;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int lat    = 4;
  bit spur   = 1'b0;
  int cnt    = 0;
  logic       prev_start = 1'b0;
  logic [7:0] held = '0;
  logic [7:0] exp_q[$];

  assign tx_done = tick_resp | tick_main;

  always #5 clk = ~clk;

  reporte_ciclos dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_cuenta  (cuenta),
    .i_halt    (halt),
    .i_tx_done (tx_done),
    .o_tx_start(tx_start),
    .o_tx_data (tx_data),
    .o_busy    (busy),
    .o_done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // UART transmitter model: checks each started byte, returns tx_done after lat cycles.
  always @(negedge clk) begin
    tick_resp = 1'b0;
    if (!rst_n) begin
      cnt        = 0;
      prev_start = 1'b0;
    end else begin
      if (cnt > 0) begin
        check("data_hold", 32'(tx_data), 32'(held));
        cnt--;
        if (cnt == 0) tick_resp = 1'b1;
      end
      if (tx_start) begin
        starts++;
        check("start_one_cycle", 32'(prev_start), 0);
        check("start_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        held = tx_data;
        cnt  = lat;
        if (spur) tick_resp = 1'b1;
      end
      prev_start = tx_start;
    end
  end

  task automatic push_frame(input logic [10:0] val);
    exp_q.push_back(8'hA5);
    exp_q.push_back(val[7:0]);
    exp_q.push_back(8'(val >> 8));
  endtask

  task automatic run_frame(input logic [10:0] val, input bit noisy);
    int s0;
    bit seen_done;
    halt = 1'b0;
    repeat (2) @(negedge clk);
    s0     = starts;
    cuenta = val;
    halt   = 1'b1;
    push_frame(val);
    @(negedge clk);
    check("busy_start", 32'(busy), 1);
    seen_done = 1'b0;
    for (int i = 0; i < 300 && !seen_done; i++) begin
      @(negedge clk);
      if (done) begin
        seen_done = 1'b1;
        halt      = 1'b1;
      end else begin
        check("busy_frame", 32'(busy), 1);
        if (noisy) begin
          cuenta = 11'($urandom);
          halt   = 1'($urandom);
        end
      end
    end
    check("frame_done", 32'(seen_done), 1);
    check("frame_starts", 32'(starts - s0), 3);
    check("queue_empty", 32'(exp_q.size()), 0);
    check("busy_after", 32'(busy), 0);
  endtask

  initial begin
    int s0;
    rst_n     = 1'b0;
    halt      = 1'b1;
    cuenta    = '0;
    tick_main = 1'b0;
    #1;
    check("rst_start", 32'(tx_start), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_frame_halt_high", 32'(starts), 0);
    check("idle_busy", 32'(busy), 0);

    lat = 4;
    run_frame(11'h5A3, 1'b0);
    run_frame(11'h000, 1'b0);
    run_frame(11'h7FF, 1'b0);

    // Halt held high after DONE must not retrigger; a low then high re-arms.
    s0 = starts;
    repeat (10) @(negedge clk);
    check("done_held", 32'(done), 1);
    check("no_rearm", 32'(starts - s0), 0);
    halt = 1'b0;
    @(negedge clk);
    check("done_fall", 32'(done), 0);
    run_frame(11'($urandom), 1'b0);

    // Spurious tx_done in IDLE and coincident with tx_start.
    halt = 1'b0;
    repeat (2) @(negedge clk);
    s0 = starts;
    tick_main = 1'b1;
    @(negedge clk);
    tick_main = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_tick_starts", 32'(starts - s0), 0);
    check("idle_tick_busy", 32'(busy), 0);
    spur = 1'b1;
    lat  = 3;
    run_frame(11'($urandom), 1'b0);
    spur = 1'b0;

    // Frozen capture under noisy count and halt, random UART latency.
    for (int k = 0; k < 6; k++) begin
      lat = $urandom_range(1, 6);
      run_frame(11'($urandom), 1'b1);
    end

    // Reset while waiting on byte 1 aborts the frame.
    lat  = 6;
    halt = 1'b0;
    repeat (2) @(negedge clk);
    s0     = starts;
    cuenta = 11'($urandom);
    halt   = 1'b1;
    push_frame(cuenta);
    for (int i = 0; i < 100 && starts < s0 + 2; i++) @(negedge clk);
    check("reach_byte1", 32'(starts - s0), 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_start", 32'(tx_start), 0);
    check("abort_done", 32'(done), 0);
    check("abort_data", 32'(tx_data), 0);
    exp_q.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_starts", 32'(starts - s0), 2);
    check("post_rst_busy", 32'(busy), 0);

    lat = $urandom_range(1, 6);
    run_frame(11'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reporte_ciclos.md
REPORTE_CICLOS -- requirements
Module: reporte_ciclos

Interface
REQ-001 SHALL have parameter CONTADOR_LENGTH, default 11, width of the captured cycle count; legal range 9..16.
REQ-002 SHALL have parameter NB_DATA, default 8, UART byte width; fixed at 8.
REQ-003 SHALL have parameter HEADER, default 8'hA5, framing byte sent before the count.
REQ-004 SHALL have port i_clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset  input  1  reset; asynchronous and active-low (0 = reset).
REQ-006 SHALL have port i_cuenta  input  CONTADOR_LENGTH  running cycle count from the upstream cycle counter.
REQ-007 SHALL have port i_halt  input  1  processor-halted level (1 = program finished).
REQ-008 SHALL have port i_tx_done  input  1  one-cycle tick from the UART transmitter: current byte sent.
REQ-009 SHALL have port o_tx_start  output  1  one-cycle request to the UART transmitter to send o_tx_data.
REQ-010 SHALL have port o_tx_data  output  NB_DATA  byte to transmit; held stable from o_tx_start until i_tx_done.
REQ-011 SHALL have port o_busy  output  1  high while a report frame is in progress.
REQ-012 SHALL have port o_done  output  1  high after the full frame is sent, until re-armed.

Function
REQ-013 SHALL implement states IDLE, SEND, WAIT, DONE, with a 2-bit byte index (0 = header, 1 = count low, 2 = count high).
REQ-014 SHALL detect a rising edge of i_halt: i_halt registered 0 on the previous edge and sampled 1 on the current edge.
REQ-015 SHALL, on a rising edge of i_halt in IDLE, capture i_cuenta into an internal register on that same clock edge, clear the index to 0 and go to SEND.
REQ-016 SHALL, in SEND, assert o_tx_start for exactly one cycle with o_tx_data = the byte selected by the index, then go to WAIT.
REQ-017 SHALL select the bytes as: index 0 = HEADER; index 1 = captured[7:0]; index 2 = captured[CONTADOR_LENGTH-1:8], zero-extended to 8 bits.
REQ-018 SHALL, in WAIT, ignore i_tx_done in the cycle where o_tx_start is high, and act only on i_tx_done sampled in WAIT.
REQ-019 SHALL, on i_tx_done in WAIT with index < 2, increment the index and go to SEND; the next o_tx_start then follows one cycle later.
REQ-020 SHALL, on i_tx_done in WAIT with index = 2, go to DONE.
REQ-021 SHALL drive o_busy = 1 in SEND and WAIT, and 0 otherwise.
REQ-022 SHALL drive o_done = 1 only in DONE.
REQ-023 SHALL leave DONE for IDLE when i_halt is sampled 0; a new frame then requires a new rising edge.
REQ-024 SHALL ignore changes of i_halt and i_cuenta while in SEND or WAIT; the captured value is frozen for the whole frame.
REQ-025 SHALL ignore i_tx_done in IDLE and DONE.
REQ-026 SHALL send any captured value as-is, including 0 and the wrapped value 2^CONTADOR_LENGTH-1; no saturation or correction.
REQ-027 SHALL not start a frame if i_halt is already 1 when reset is released; an edge is required (the halt register resets to 1).

Reset
REQ-028 SHALL, while i_reset = 0, immediately (asynchronously) force: state IDLE, index 0, captured value 0, halt register 1, o_tx_start 0, o_tx_data 0, o_busy 0, o_done 0.
REQ-029 SHALL abort any frame in progress when reset asserts mid-frame; no further o_tx_start is issued until a new rising edge of i_halt after reset release.

Verification
REQ-030 Basic frame: i_cuenta = 11'h5A3, i_halt 0->1, i_tx_done returned 4 cycles after each start -> bytes A5, A3, 05 in that order; o_busy high throughout; then o_done = 1.
REQ-031 Boundaries: i_cuenta = 0 gives bytes A5, 00, 00; i_cuenta = 11'h7FF gives bytes A5, FF, 07.
REQ-032 Frozen capture: i_cuenta changes every cycle and i_halt toggles during the frame -> the bytes reflect the value at the capture edge; exactly 3 o_tx_start pulses are issued.
REQ-033 Re-arm: i_halt held 1 after DONE -> no new frame; i_halt 1->0->1 -> o_done falls and a second complete frame is sent.
REQ-034 Reset mid-frame: i_reset = 0 while in WAIT for byte 1 -> o_busy and o_tx_start go 0 at once; i_halt held 1 across reset release -> no frame is sent.
REQ-035 Spurious ticks: i_tx_done pulsed in IDLE, and in the same cycle as o_tx_start -> no byte is advanced and no extra o_tx_start is issued.
